nexys4ddr_uart_rx: RTL and testbench



---
 rtl/nexys4ddr_uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_nexys4ddr_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nexys4ddr_uart_rx.sv
// 16x oversampled UART receiver with glitch-filtered start, FWFT FIFO and CTS.
// Define NEXYS4DDR_UART_RX_PARITY_EN to build an 8E1 receiver instead of 8N1.
module nexys4ddr_uart_rx #(
   parameter int unsigned BAUD_DIV      = 54,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned CTS_THRESHOLD = 12
) (
   input  logic       clk,
   input  logic       cpu_resetn,
   input  logic       uart_txd_in,
   output logic       uart_cts,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err_frame,
   output logic       err_overrun,
   output logic       err_parity
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_e;

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          rxd;
   logic [BW-1:0] baud_q, baud_d;
   logic          tick;
   logic          mid;
   logic [3:0]    smp_q, smp_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_bad_q, par_bad_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          cts_q;
   logic          frame_q, ovr_q;
   logic          push, pop, full;
   logic          stop_mid;
   logic          frame_hit, ovr_hit, par_hit;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
   logic          par_q;
`endif

   assign rxd  = sync2_q;
   assign tick = (baud_q == BW'(BAUD_DIV - 1));
   assign mid  = tick && (smp_q == 4'hF);

   always_ff @(posedge clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         baud_q    <= '0;
         smp_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         cts_q     <= 1'b1;
         frame_q   <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sync1_q   <= uart_txd_in;
         sync2_q   <= sync1_q;
         baud_q    <= baud_d;
         smp_q     <= smp_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         cts_q     <= (cnt_d >= (AW+1)'(CTS_THRESHOLD));
         frame_q   <= frame_hit;
         ovr_q     <= ovr_hit;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
         par_q     <= par_hit;
`endif
      end
   end

   // Storage needs no reset: out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= shift_q;
   end

   always_comb begin
      state_d   = state_q;
      smp_d     = tick ? smp_q + 4'd1 : smp_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      baud_d    = tick ? '0 : baud_q + BW'(1);
      unique case (state_q)
         S_IDLE: begin
            if (!rxd) begin
               state_d = S_START;
               smp_d   = '0;
               baud_d  = '0;
            end
         end
         S_START: begin
            if (tick && smp_q == 4'd7) begin
               if (rxd) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  smp_d     = '0;
                  bit_d     = '0;
                  par_bad_d = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (mid) begin
               shift_d = {rxd, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid) begin
               state_d   = S_STOP;
               par_bad_d = (rxd != ^shift_q);
            end
         end
`endif
         S_STOP: begin
            if (mid) state_d = rxd ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            if (rxd) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO being popped this cycle still accepts the new byte.
   always_comb begin
      pop       = out_valid && out_ready;
      full      = (cnt_q == (AW+1)'(FIFO_DEPTH)) && !pop;
      stop_mid  = (state_q == S_STOP) && mid;
      push      = stop_mid && rxd && !par_bad_q && !full;
      ovr_hit   = stop_mid && rxd && !par_bad_q && full;
      frame_hit = stop_mid && !rxd;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
      par_hit   = (state_q == S_PARITY) && mid && (rxd != ^shift_q);
`else
      par_hit   = 1'b0;
`endif
      wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d     = cnt_q;
      if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
      if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
   end

   assign out_valid   = (cnt_q != '0);
   assign out_data    = out_valid ? mem_q[rptr_q] : 8'h00;
   assign uart_cts    = cts_q;
   assign err_frame   = frame_q;
   assign err_overrun = ovr_q;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
   assign err_parity  = par_q;
`else
   assign err_parity  = 1'b0;
`endif

endmodule

// File: tb/tb_nexys4ddr_uart_rx.sv
// Directed bench for nexys4ddr_uart_rx: serial frames in, scoreboard on the
// byte stream, pulse counters on the error outputs.
module tb_nexys4ddr_uart_rx;

   logic       clk = 1'b0;
   logic       cpu_resetn = 1'b0;
   logic       uart_txd_in = 1'b1;
   logic       out_ready = 1'b0;
   logic       uart_cts;
   logic [7:0] out_data;
   logic       out_valid;
   logic       err_frame, err_overrun, err_parity;

   int vectors = 0;
   int miscompares = 0;
   int frame_cnt = 0;
   int ovr_cnt = 0;
   int par_cnt = 0;
   int valid_cycles = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   nexys4ddr_uart_rx #(
      .BAUD_DIV(4), .FIFO_DEPTH(16), .CTS_THRESHOLD(12)
   ) dut (
      .clk(clk), .cpu_resetn(cpu_resetn), .uart_txd_in(uart_txd_in),
      .uart_cts(uart_cts), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .err_frame(err_frame),
      .err_overrun(err_overrun), .err_parity(err_parity)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cpu_resetn) begin
         frame_cnt    += int'(err_frame);
         ovr_cnt      += int'(err_overrun);
         par_cnt      += int'(err_parity);
         valid_cycles += int'(out_valid);
         if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rx_byte", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic drive_bit(input logic b);
      @(posedge clk); #1;
      uart_txd_in = b;
      repeat (63) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb,
                             input logic badpar);
      logic [10:0] f;
      int n;
`ifdef NEXYS4DDR_UART_RX_PARITY_EN
      f = {stopb, (^d) ^ badpar, d, 1'b0};
      n = 11;
`else
      f = {badpar, stopb, d, 1'b0};
      n = 10;
`endif
      for (int i = 0; i < n; i++) drive_bit(f[i]);
      idle(8);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      // Reset state
      idle(4);
      check("rst_cts", uart_cts, 1);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_errs", {err_frame, err_overrun, err_parity}, 0);
      cpu_resetn = 1'b1;
      idle(2);
      check("cts_after_rst", uart_cts, 0);

      // 1: single byte
      out_ready = 1'b1;
      valid_cycles = 0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      wait_drain("s1_drain");
      idle(32);
      check("s1_valid_cycles", valid_cycles, 1);
      check("s1_errs", frame_cnt + ovr_cnt + par_cnt, 0);

      // 2: start glitch
      @(posedge clk); #1;
      uart_txd_in = 1'b0;
      idle(20);
      uart_txd_in = 1'b1;
      valid_cycles = 0;
      idle(200);
      check("s2_no_push", valid_cycles, 0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      wait_drain("s2_drain");

      // 3: framing error followed by a held break
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(1280);
      check("s3_frame_once", frame_cnt, 1);
      check("s3_no_push", out_valid, 0);
      uart_txd_in = 1'b1;
      idle(64);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1'b0);
      wait_drain("s3_drain");
      check("s3_frame_total", frame_cnt, 1);

      // 4: fill, overrun, drain
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(8'(i));
         send_frame(8'(i), 1'b1, 1'b0);
         check($sformatf("s4_cts_%0d", i), uart_cts, ((i + 1) >= 12) ? 1 : 0);
      end
      check("s4_overrun", ovr_cnt, 1);
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check($sformatf("s4_drain_cts_%0d", k), uart_cts,
               ((15 - k) >= 12) ? 1 : 0);
      end
      idle(2);
      check("s4_empty", out_valid, 0);
      check("s4_sb_empty", exp_q.size(), 0);

      // 5: reset in the middle of a frame with bytes queued
      for (int i = 0; i < 3; i++) send_frame(8'hE0 + 8'(i), 1'b1, 1'b0);
      check("s5_queued", out_valid, 1);
      drive_bit(1'b0);
      @(posedge clk); #1;
      uart_txd_in = 1'b1;
      idle(4 * 64 + 32);
      cpu_resetn = 1'b0;
      idle(3);
      check("s5_rst_valid", out_valid, 0);
      check("s5_rst_cts", uart_cts, 1);
      check("s5_rst_data", out_data, 0);
      idle(5);
      cpu_resetn = 1'b1;
      idle(400);
      check("s5_no_partial", out_valid, 0);
      out_ready = 1'b1;
      valid_cycles = 0;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      wait_drain("s5_drain");
      idle(100);
      check("s5_only_one", valid_cycles, 1);

`ifdef NEXYS4DDR_UART_RX_PARITY_EN
      // 6: parity error then good parity
      send_frame(8'h07, 1'b1, 1'b1);
      idle(32);
      check("s6_par_once", par_cnt, 1);
      check("s6_no_push", out_valid, 0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_drain("s6_drain");
      check("s6_par_total", par_cnt, 1);
`else
      check("no_parity_pulses", par_cnt, 0);
`endif
      check("final_frame", frame_cnt, 1);
      check("final_overrun", ovr_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
